rr_stream_mux: RTL and testbench
================================

// Module: rr_stream_mux
// PURPOSE
//  Parametrised N:1 stream multiplexer; successor to the 4:1 combinational mux.
//  Selects one of CHANNELS valid/ready input streams per cycle, with round-robin or fixed-priority arbitration.
//  Holds the grant for a whole packet, delimited by in_last.
//  Registers the selected beat with its channel index. Sits between per-channel producers and one shared consumer.
// PARAMETERS
//  WIDTH     8  data bits per channel
//  CHANNELS  4  number of input streams (>=2)
//  CH_W      $clog2(CHANNELS)  index width (localparam, min 1)
// PORTS
//  clk        in   1                 rising-edge clock; single clock domain
//  rst_n      in   1                 asynchronous, active-low reset
//  mode_rr    in   1                 1=round-robin, 0=fixed priority (lowest index wins)
//  in_valid   in   CHANNELS          per-channel beat valid
//  in_last    in   CHANNELS          per-channel end-of-packet flag
//  in_data    in   CHANNELS*WIDTH    packed data, channel i at [i*WIDTH +: WIDTH]
//  in_ready   out  CHANNELS          per-channel accept (combinational)
//  out_valid  out  1                 registered beat valid
//  out_data   out  WIDTH             registered data
//  out_last   out  1                 registered end-of-packet
//  out_chan   out  CH_W              source channel of current out beat
//  out_ready  in   1                 consumer accept
// BEHAVIOUR
//  Reset (async assert, sync release): out_valid=0, out_data=0, out_last=0, out_chan=0; state=IDLE; rr_ptr=CHANNELS-1, so channel 0 is first.
//  load = !out_valid || out_ready. Output register loads only when load=1. Latency 1 clk; full throughput (1 beat/clk).
//  in_ready[i] = load && grant[i]; at most one bit set. Transfer on channel i = in_valid[i] && in_ready[i].
//  A grant requires in_valid; in_ready never asserts for an idle channel.
//  Consumer stall (out_valid && !out_ready): all in_ready=0; out_* held stable.
//  On load with no transfer: out_valid<=0; out_data, out_last, out_chan hold their values.
//  FSM IDLE: arbitrate among in_valid.
//    Round-robin: search rr_ptr+1, rr_ptr+2, ... mod CHANNELS; first valid wins.
//    Fixed priority: lowest valid index wins.
//    Transfer with in_last=0 -> LOCKED(lock_ch=grant); in_last=1 -> stay IDLE (single-beat packet).
//  FSM LOCKED: grant forced to lock_ch regardless of other valids or mode.
//    If in_valid[lock_ch]=0, no transfer (bubble). Transfer with in_last=1 -> IDLE.
//  rr_ptr <= granted index on each packet-ending transfer (in_last=1), in both modes.
//  mode_rr sampled only in IDLE; a change mid-packet takes effect at next arbitration.
//  Transfer beat and rr_ptr wrap-around: index CHANNELS-1 -> 0.
//  Reset mid-packet: lock dropped, pending out beat discarded; upstream resends.
// STRUCTURE
//  Shared package rr_mux_pkg: FSM state enum {IDLE, LOCKED}, MODE_FIXED/MODE_RR constants.
//  Sub-module rr_arbiter #(CHANNELS): req, ptr, mode_rr -> one-hot grant + index; purely combinational.
//  Top level holds the FSM, lock_ch, rr_ptr, output register and data select.
// TESTING
//  1 Reset: rst_n=0 mid-traffic -> all out_* =0 and in_ready=0 immediately; after release, first grant goes to ch0.
//  2 RR fairness: all 4 valid, single-beat packets, out_ready=1 -> out_chan 0,1,2,3,0,... one beat/clk.
//  3 Fixed priority: mode_rr=0, ch1 and ch3 valid continuously -> only ch1 granted; ch3 waits until ch1 drops valid.
//  4 Packet lock: ch2 sends a 3-beat packet while ch0 valid -> beats ch2,ch2,ch2(last), then ch0. Bubble on ch2 holds the lock.
//  5 Backpressure: out_ready=0 for 3 clk with out_valid=1 -> out_data stable, in_ready=0; resume -> no beat lost or duplicated.
//  6 Random: CHANNELS=5, WIDTH=16, random valid/last/ready, 10k cycles; scoreboard checks per-channel order and packet contiguity.
//  Checker: one-hot in_ready; out_* stable under stall.

Source files
------------

// File: rtl/rr_mux_pkg.sv
// Shared definitions for the round-robin stream multiplexer.
//   state_e     : packet FSM state (IDLE arbitrates, LOCKED holds a packet's grant)
//   MODE_FIXED  : mode_rr value selecting fixed priority (lowest index wins)
//   MODE_RR     : mode_rr value selecting round-robin
//   idx_w()     : channel index width, never below 1
package rr_mux_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way arbiter.
//   req     in   CHANNELS  per-channel request (in_valid)
//   ptr     in   CH_W      last packet-ending winner; round-robin starts at ptr+1
//   mode_rr in   1         MODE_RR: rotating search, MODE_FIXED: lowest index
//   grant   out  CHANNELS  one-hot grant, all zero when nothing requests
//   idx     out  CH_W      index of the granted channel (0 when no grant)
module rr_arbiter
  import rr_mux_pkg::*;
#(
  parameter  int CHANNELS = 4,
  localparam int CH_W     = idx_w(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [CH_W-1:0]     ptr,
  input  logic                mode_rr,
  output logic [CHANNELS-1:0] grant,
  output logic [CH_W-1:0]     idx
);

  logic            found;
  logic [CH_W-1:0] c;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    c     = '0;
    if (mode_rr == MODE_RR) begin
      // Walk ptr+1 .. ptr+CHANNELS, so the previous winner is checked last.
      for (int k = 1; k <= CHANNELS; k++) begin
        c = CH_W'((int'(ptr) + k) % CHANNELS);
        if (!found && req[c]) begin
          found    = 1'b1;
          grant[c] = 1'b1;
          idx      = c;
        end
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        c = CH_W'(k);
        if (!found && req[c]) begin
          found    = 1'b1;
          grant[c] = 1'b1;
          idx      = c;
        end
      end
    end
  end

endmodule

// File: rtl/rr_stream_mux.sv
// N:1 valid/ready stream multiplexer with packet-level grant locking.
//   clk, rst_n  clock, asynchronous active-low reset
//   mode_rr     1 = round-robin, 0 = fixed priority (sampled between packets)
//   in_valid    per-channel beat valid
//   in_last     per-channel end-of-packet
//   in_data     packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_ready    per-channel accept, combinational, at most one bit set
//   out_valid   registered beat valid
//   out_data    registered beat data
//   out_last    registered end-of-packet
//   out_chan    source channel of the registered beat
//   out_ready   consumer accept
module rr_stream_mux
  import rr_mux_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  localparam int CH_W     = idx_w(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode_rr,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS-1:0]       in_last,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_last,
  output logic [CH_W-1:0]           out_chan,
  input  logic                      out_ready
);

  state_e              state;
  logic [CH_W-1:0]     lock_ch;
  logic [CH_W-1:0]     rr_ptr;

  logic [CHANNELS-1:0] arb_grant;
  logic [CH_W-1:0]     arb_idx;
  logic [CHANNELS-1:0] grant;
  logic [CH_W-1:0]     sel_idx;
  logic                load;
  logic                xfer;
  logic                sel_last;
  logic [WIDTH-1:0]    sel_data;

  rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
    .req     (in_valid),
    .ptr     (rr_ptr),
    .mode_rr (mode_rr),
    .grant   (arb_grant),
    .idx     (arb_idx)
  );

  // Output register is free when empty or being drained this cycle.
  assign load = !out_valid || out_ready;

  // While locked the arbiter is ignored; an idle locked channel is a bubble.
  always_comb begin
    grant   = '0;
    sel_idx = arb_idx;
    if (state == LOCKED) begin
      sel_idx        = lock_ch;
      grant[lock_ch] = in_valid[lock_ch];
    end else begin
      grant = arb_grant;
    end
  end

  // Gating with rst_n keeps in_ready low for the whole reset, not just after it.
  assign in_ready = (load && rst_n) ? grant : '0;
  assign xfer     = |(in_valid & in_ready);
  assign sel_last = in_last[sel_idx];
  assign sel_data = in_data[int'(sel_idx)*WIDTH +: WIDTH];

  // Output register: data/last/chan hold when a load slot carries no beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_chan  <= '0;
    end else if (load) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= sel_data;
        out_last <= sel_last;
        out_chan <= sel_idx;
      end
    end
  end

  // Packet FSM; rr_ptr starts at the top index so channel 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      lock_ch <= '0;
      rr_ptr  <= CH_W'(CHANNELS-1);
    end else if (xfer) begin
      if (sel_last) begin
        state  <= IDLE;
        rr_ptr <= sel_idx;
      end else begin
        state   <= LOCKED;
        lock_ch <= sel_idx;
      end
    end
  end

endmodule

// File: tb/tb_rr_stream_mux.sv
// Self-checking bench for rr_stream_mux (5 channels, 16-bit data):
// directed reset/fairness/priority/lock/backpressure scenarios plus a
// randomized run against a packet-level reference model.
module tb_rr_stream_mux;

  localparam int N  = 5;
  localparam int W  = 16;
  localparam int CW = 3;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               mode_rr = 1'b1;
  logic [N-1:0]       in_valid = '0;
  logic [N-1:0]       in_last = '0;
  logic [N-1:0][W-1:0] d_arr = '0;
  logic [N*W-1:0]     in_data;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic [W-1:0]       out_data;
  logic               out_last;
  logic [CW-1:0]      out_chan;
  logic               out_ready = 1'b1;

  int n_cmp = 0;
  int n_err = 0;

  assign in_data = d_arr;

  always #5 clk = ~clk;

  rr_stream_mux #(.WIDTH(W), .CHANNELS(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode_rr   (mode_rr),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_chan  (out_chan),
    .out_ready (out_ready)
  );

  task automatic set_in(input logic [N-1:0] v, input logic [N-1:0] l, input logic r);
    in_valid  = v;
    in_last   = l;
    out_ready = r;
  endtask

  task automatic const_data();
    for (int c = 0; c < N; c++) d_arr[c] = 16'hD000 + 16'(c);
  endtask

  // Ends one ns after a rising edge with reset released.
  task automatic do_reset();
    set_in('0, '0, 1'b1);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [N-1:0] e;
    do_reset();
    const_data();
    mode_rr = 1'b1;
    set_in('1, '1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0 || out_chan !== '0) begin
      n_err++;
      $display("FAIL reset_out: got v=%b d=%h l=%b c=%0d expected all zero", out_valid, out_data, out_last, out_chan);
    end
    n_cmp++;
    if (in_ready !== '0) begin
      n_err++;
      $display("FAIL reset_ready: got %b expected 0", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    e = 5'b00001;
    n_cmp++;
    if (in_ready !== e) begin
      n_err++;
      $display("FAIL reset_first_ready: got %b expected %b", in_ready, e);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b1 || out_chan !== 3'd0) begin
      n_err++;
      $display("FAIL reset_first_grant: got v=%b c=%0d expected v=1 c=0", out_valid, out_chan);
    end
  endtask

  task automatic test_rr_fair();
    logic [N-1:0] e;
    do_reset();
    const_data();
    mode_rr = 1'b1;
    set_in('1, '1, 1'b1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      e = '0;
      e[i % N] = 1'b1;
      n_cmp++;
      if (in_ready !== e) begin
        n_err++;
        $display("FAIL rr_ready[%0d]: got %b expected %b", i, in_ready, e);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_chan !== CW'(i % N) || out_data !== 16'hD000 + 16'(i % N)) begin
        n_err++;
        $display("FAIL rr_beat[%0d]: got v=%b c=%0d d=%h expected v=1 c=%0d d=%h",
                 i, out_valid, out_chan, out_data, i % N, 16'hD000 + 16'(i % N));
      end
    end
  endtask

  task automatic test_fixed();
    do_reset();
    const_data();
    mode_rr = 1'b0;
    set_in(5'b01010, '1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 5'b00010) begin
        n_err++;
        $display("FAIL fixed_ready[%0d]: got %b expected 00010", i, in_ready);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_chan !== 3'd1) begin
        n_err++;
        $display("FAIL fixed_chan[%0d]: got v=%b c=%0d expected v=1 c=1", i, out_valid, out_chan);
      end
    end
    set_in(5'b01000, '1, 1'b1);
    @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b1 || out_chan !== 3'd3) begin
      n_err++;
      $display("FAIL fixed_fallback: got v=%b c=%0d expected v=1 c=3", out_valid, out_chan);
    end
  endtask

  task automatic test_lock();
    logic [N-1:0] tv [5] = '{5'b00100, 5'b00101, 5'b00001, 5'b00101, 5'b00001};
    logic [N-1:0] tl [5] = '{5'b00000, 5'b00001, 5'b00001, 5'b00101, 5'b00001};
    logic [N-1:0] tr [5] = '{5'b00100, 5'b00100, 5'b00000, 5'b00100, 5'b00001};
    logic         tm [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic         eo [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    int           ec [5] = '{2, 2, 2, 2, 0};
    logic         el [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    const_data();
    for (int i = 0; i < 5; i++) begin
      mode_rr  = tm[i];
      d_arr[2] = 16'h2200 + 16'(i);
      set_in(tv[i], tl[i], 1'b1);
      @(negedge clk);
      n_cmp++;
      if (in_ready !== tr[i]) begin
        n_err++;
        $display("FAIL lock_ready[%0d]: got %b expected %b", i, in_ready, tr[i]);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid !== eo[i] || (eo[i] && (out_chan !== CW'(ec[i]) || out_last !== el[i]))) begin
        n_err++;
        $display("FAIL lock_beat[%0d]: got v=%b c=%0d l=%b expected v=%b c=%0d l=%b",
                 i, out_valid, out_chan, out_last, eo[i], ec[i], el[i]);
      end
      if (eo[i] && ec[i] == 2) begin
        n_cmp++;
        if (out_data !== 16'h2200 + 16'(i)) begin
          n_err++;
          $display("FAIL lock_data[%0d]: got %h expected %h", i, out_data, 16'h2200 + 16'(i));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held;
    do_reset();
    const_data();
    mode_rr = 1'b1;
    set_in('1, '1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    held = out_data;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (in_ready !== '0) begin
        n_err++;
        $display("FAIL bp_ready[%0d]: got %b expected 0", i, in_ready);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_chan !== 3'd1 || out_data !== held || held !== 16'hD001) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got v=%b c=%0d d=%h expected v=1 c=1 d=d001", i, out_valid, out_chan, out_data);
      end
    end
    out_ready = 1'b1;
    for (int i = 2; i < 4; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_chan !== CW'(i)) begin
        n_err++;
        $display("FAIL bp_resume[%0d]: got v=%b c=%0d expected v=1 c=%0d", i, out_valid, out_chan, i);
      end
    end
  endtask

  task automatic test_random();
    // Reference model state: packet lock, last packet-ending winner, output slot.
    logic         m_locked;
    int           m_lock;
    int           m_ptr;
    logic         m_ov;
    logic [W-1:0] m_od;
    logic         m_ol;
    int           m_oc;
    logic [N-1:0] e;
    logic         ld;
    int           g;
    int           c;
    // Stall / consumer-side bookkeeping.
    logic         p_ov, p_ol, stall, in_pkt;
    logic [W-1:0] p_od;
    logic [CW-1:0] p_oc;
    int           pkt_ch;
    do_reset();
    m_locked = 1'b0; m_lock = 0; m_ptr = N-1;
    m_ov = 1'b0; m_od = '0; m_ol = 1'b0; m_oc = 0;
    in_pkt = 1'b0; pkt_ch = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int k = 0; k < N; k++) begin
        in_valid[k] = ($urandom_range(0, 99) < 55);
        in_last[k]  = ($urandom_range(0, 99) < 35);
        d_arr[k]    = W'($urandom);
      end
      out_ready = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 99) < 3) mode_rr = ~mode_rr;

      @(negedge clk);
      ld = !m_ov || out_ready;
      g  = -1;
      if (m_locked) begin
        if (in_valid[m_lock]) g = m_lock;
      end else if (mode_rr) begin
        for (int k = 1; k <= N; k++) begin
          c = (m_ptr + k) % N;
          if (g < 0 && in_valid[c]) g = c;
        end
      end else begin
        for (int k = 0; k < N; k++) if (g < 0 && in_valid[k]) g = k;
      end
      if (!ld) g = -1;
      e = '0;
      if (g >= 0) e[g] = 1'b1;
      n_cmp++;
      if (in_ready !== e) begin
        n_err++;
        $display("FAIL rand_ready@%0d: got %b expected %b", cyc, in_ready, e);
      end
      n_cmp++;
      if ($countones(in_ready) > 1) begin
        n_err++;
        $display("FAIL rand_onehot@%0d: got %b expected at most one bit", cyc, in_ready);
      end
      p_ov = out_valid; p_od = out_data; p_ol = out_last; p_oc = out_chan;
      stall = out_valid && !out_ready;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (in_pkt && int'(out_chan) != pkt_ch) begin
          n_err++;
          $display("FAIL rand_contig@%0d: got chan %0d expected %0d", cyc, out_chan, pkt_ch);
        end
        in_pkt = !out_last;
        pkt_ch = int'(out_chan);
      end
      if (ld) begin
        m_ov = (g >= 0);
        if (g >= 0) begin
          m_od = d_arr[g]; m_ol = in_last[g]; m_oc = g;
        end
      end
      if (g >= 0) begin
        if (in_last[g]) begin
          m_locked = 1'b0; m_ptr = g;
        end else begin
          m_locked = 1'b1; m_lock = g;
        end
      end

      @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid !== m_ov || out_data !== m_od || out_last !== m_ol || out_chan !== CW'(m_oc)) begin
        n_err++;
        $display("FAIL rand_out@%0d: got v=%b d=%h l=%b c=%0d expected v=%b d=%h l=%b c=%0d",
                 cyc, out_valid, out_data, out_last, out_chan, m_ov, m_od, m_ol, m_oc);
      end
      if (stall) begin
        n_cmp++;
        if (out_valid !== p_ov || out_data !== p_od || out_last !== p_ol || out_chan !== p_oc) begin
          n_err++;
          $display("FAIL rand_stall@%0d: got v=%b d=%h l=%b c=%0d expected v=%b d=%h l=%b c=%0d",
                   cyc, out_valid, out_data, out_last, out_chan, p_ov, p_od, p_ol, p_oc);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_rr_fair();
    test_fixed();
    test_lock();
    test_backpressure();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
